// File: rtl/reg_read_fwd.sv
// Register-read stage: per-port operand forwarding (EX > WB > register file), load-use
// stall detection and a valid/ready output register. Optional counters: REG_READ_FWD_STATS_EN.
module reg_read_fwd #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_NUM_WIDTH  = 4,
  parameter int NUM_REGISTERS  = 16,
  parameter int NUM_READ_PORTS = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NUM_READ_PORTS*REG_NUM_WIDTH-1:0]  rn,
  input  logic [NUM_READ_PORTS-1:0]                rn_en,
  input  logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0] rfile_data,
  input  logic                                     ex_wr_en,
  input  logic [REG_NUM_WIDTH-1:0]                 ex_wr_num,
  input  logic                                     ex_wr_data_valid,
  input  logic [REG_DATA_WIDTH-1:0]                ex_wr_data,
  input  logic                                     wb_wr_en,
  input  logic [REG_NUM_WIDTH-1:0]                 wb_wr_num,
  input  logic [REG_DATA_WIDTH-1:0]                wb_wr_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0] rd,
  output logic [NUM_READ_PORTS-1:0]                exception,
  output logic [NUM_READ_PORTS*2-1:0]              fwd_sel
`ifdef REG_READ_FWD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]                     stall_cnt,
  output logic [CNT_WIDTH-1:0]                     fwd_ex_cnt,
  output logic [CNT_WIDTH-1:0]                     fwd_wb_cnt
`endif
);

  // One extra bit so NUM_REGISTERS == 2**REG_NUM_WIDTH is representable.
  localparam logic [REG_NUM_WIDTH:0] NUM_REGS_W = NUM_REGISTERS[REG_NUM_WIDTH:0];

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_WB = 2'b01;
  localparam logic [1:0] SEL_EX = 2'b10;

  logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0] w_rd;
  logic [NUM_READ_PORTS-1:0]                w_exc;
  logic [NUM_READ_PORTS*2-1:0]              w_sel;
  logic [NUM_READ_PORTS-1:0]                w_hazard_p;
  logic                                     w_hazard;
  logic                                     w_accept;
  logic                                     w_any_ex;
  logic                                     w_any_wb;

  logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0] r_rd;
  logic [NUM_READ_PORTS-1:0]                r_exc;
  logic [NUM_READ_PORTS*2-1:0]              r_sel;
  logic                                     r_out_valid;

  always_comb begin
    w_rd       = '0;
    w_exc      = '0;
    w_sel      = '0;
    w_hazard_p = '0;
    w_any_ex   = 1'b0;
    w_any_wb   = 1'b0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (rn_en[p]) begin
        if ({1'b0, rn[p*REG_NUM_WIDTH +: REG_NUM_WIDTH]} >= NUM_REGS_W) begin
          w_exc[p] = 1'b1;
        end else if (ex_wr_en && (ex_wr_num == rn[p*REG_NUM_WIDTH +: REG_NUM_WIDTH])) begin
          // A load still in flight in EX must stall rather than fall through to WB/rfile.
          if (ex_wr_data_valid) begin
            w_rd[p*REG_DATA_WIDTH +: REG_DATA_WIDTH] = ex_wr_data;
            w_sel[p*2 +: 2]                          = SEL_EX;
            w_any_ex                                 = 1'b1;
          end else begin
            w_hazard_p[p] = 1'b1;
          end
        end else if (wb_wr_en && (wb_wr_num == rn[p*REG_NUM_WIDTH +: REG_NUM_WIDTH])) begin
          w_rd[p*REG_DATA_WIDTH +: REG_DATA_WIDTH] = wb_wr_data;
          w_sel[p*2 +: 2]                          = SEL_WB;
          w_any_wb                                 = 1'b1;
        end else begin
          w_rd[p*REG_DATA_WIDTH +: REG_DATA_WIDTH] = rfile_data[p*REG_DATA_WIDTH +: REG_DATA_WIDTH];
          w_sel[p*2 +: 2]                          = SEL_RF;
        end
      end
    end
  end

  assign w_hazard = |w_hazard_p;
  assign in_ready = rst && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_rd        <= '0;
      r_exc       <= '0;
      r_sel       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_rd        <= w_rd;
      r_exc       <= w_exc;
      r_sel       <= w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign rd        = r_rd;
  assign exception = r_exc;
  assign fwd_sel   = r_sel;

`ifdef REG_READ_FWD_STATS_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_fwd_ex_cnt;
  logic [CNT_WIDTH-1:0] r_fwd_wb_cnt;

  // Saturating counters; they stick at all-ones until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_fwd_ex_cnt <= '0;
      r_fwd_wb_cnt <= '0;
    end else begin
      if (in_valid && w_hazard && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_accept && w_any_ex && (r_fwd_ex_cnt != '1)) r_fwd_ex_cnt <= r_fwd_ex_cnt + 1'b1;
      if (w_accept && w_any_wb && (r_fwd_wb_cnt != '1)) r_fwd_wb_cnt <= r_fwd_wb_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign fwd_ex_cnt = r_fwd_ex_cnt;
  assign fwd_wb_cnt = r_fwd_wb_cnt;
`endif

endmodule

// File: tb/tb_reg_read_fwd.sv
// Bench for reg_read_fwd: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the forwarding/handshake rules.
module tb_reg_read_fwd;
  localparam int DW   = 16;
  localparam int RNW  = 4;
  localparam int NREG = 12;
  localparam int NRP  = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NRP*RNW-1:0] rn;
  logic [NRP-1:0]    rn_en;
  logic [NRP*DW-1:0] rfile_data;
  logic              ex_wr_en;
  logic [RNW-1:0]    ex_wr_num;
  logic              ex_wr_data_valid;
  logic [DW-1:0]     ex_wr_data;
  logic              wb_wr_en;
  logic [RNW-1:0]    wb_wr_num;
  logic [DW-1:0]     wb_wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [NRP*DW-1:0] rd;
  logic [NRP-1:0]    exception;
  logic [NRP*2-1:0]  fwd_sel;
`ifdef REG_READ_FWD_STATS_EN
  logic [CW-1:0]     stall_cnt;
  logic [CW-1:0]     fwd_ex_cnt;
  logic [CW-1:0]     fwd_wb_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  reg_read_fwd #(
    .REG_DATA_WIDTH(DW), .REG_NUM_WIDTH(RNW), .NUM_REGISTERS(NREG),
    .NUM_READ_PORTS(NRP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rn(rn), .rn_en(rn_en), .rfile_data(rfile_data),
    .ex_wr_en(ex_wr_en), .ex_wr_num(ex_wr_num), .ex_wr_data_valid(ex_wr_data_valid),
    .ex_wr_data(ex_wr_data), .wb_wr_en(wb_wr_en), .wb_wr_num(wb_wr_num),
    .wb_wr_data(wb_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .rd(rd), .exception(exception), .fwd_sel(fwd_sel)
`ifdef REG_READ_FWD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_ex_cnt(fwd_ex_cnt), .fwd_wb_cnt(fwd_wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NRP*DW-1:0] m_rd    = '0;
  logic [NRP-1:0]    m_exc   = '0;
  logic [NRP*2-1:0]  m_sel   = '0;
  logic              m_ov    = 1'b0;
  int                m_stall = 0;
  int                m_fex   = 0;
  int                m_fwb   = 0;

  // Evaluate one operand request from the current inputs using the priority rules.
  function automatic void eval_req(output logic [NRP*DW-1:0] d, output logic [NRP-1:0] e,
                                   output logic [NRP*2-1:0] s, output logic h,
                                   output logic any_ex, output logic any_wb);
    d = '0; e = '0; s = '0; h = 1'b0; any_ex = 1'b0; any_wb = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      int r;
      r = int'(rn[p*RNW +: RNW]);
      if (!rn_en[p]) continue;
      if (r >= NREG) begin
        e[p] = 1'b1;
      end else if (ex_wr_en && int'(ex_wr_num) == r) begin
        if (ex_wr_data_valid) begin
          d[p*DW +: DW] = ex_wr_data; s[p*2 +: 2] = 2'd2; any_ex = 1'b1;
        end else h = 1'b1;
      end else if (wb_wr_en && int'(wb_wr_num) == r) begin
        d[p*DW +: DW] = wb_wr_data; s[p*2 +: 2] = 2'd1; any_wb = 1'b1;
      end else begin
        d[p*DW +: DW] = rfile_data[p*DW +: DW];
      end
    end
  endfunction

  function automatic logic model_ready();
    logic [NRP*DW-1:0] d; logic [NRP-1:0] e; logic [NRP*2-1:0] s; logic h, ax, aw;
    eval_req(d, e, s, h, ax, aw);
    return rst && !h && (!m_ov || out_ready);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rd = '0; m_exc = '0; m_sel = '0; m_ov = 1'b0;
      m_stall = 0; m_fex = 0; m_fwb = 0;
    end else begin
      logic [NRP*DW-1:0] d; logic [NRP-1:0] e; logic [NRP*2-1:0] s; logic h, ax, aw, acc;
      eval_req(d, e, s, h, ax, aw);
      acc = in_valid && !h && (!m_ov || out_ready);
      if (in_valid && h && m_stall < CMAX) m_stall++;
      if (acc && ax && m_fex < CMAX) m_fex++;
      if (acc && aw && m_fwb < CMAX) m_fwb++;
      if (acc) begin
        m_ov = 1'b1; m_rd = d; m_exc = e; m_sel = s;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, model_ready());
    chk("out_valid", out_valid, m_ov);
    chk("rd", rd, m_rd);
    chk("exception", exception, m_exc);
    chk("fwd_sel", fwd_sel, m_sel);
`ifdef REG_READ_FWD_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("fwd_ex_cnt", fwd_ex_cnt, m_fex);
    chk("fwd_wb_cnt", fwd_wb_cnt, m_fwb);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic v, input logic [3:0] r0, input logic [3:0] r1,
                         input logic [1:0] en, input logic [15:0] f0, input logic [15:0] f1);
    in_valid = v; rn = {r1, r0}; rn_en = en; rfile_data = {f1, f0};
  endtask

  task automatic set_wr(input logic exe, input logic [3:0] exn, input logic exv,
                        input logic [15:0] exd, input logic wbe, input logic [3:0] wbn,
                        input logic [15:0] wbd);
    ex_wr_en = exe; ex_wr_num = exn; ex_wr_data_valid = exv; ex_wr_data = exd;
    wb_wr_en = wbe; wb_wr_num = wbn; wb_wr_data = wbd;
  endtask

  initial begin
    logic hold;
    rst = 1'b0;
    out_ready = 1'b1;
    set_req(1'b1, 4'd3, 4'd5, 2'b11, 16'h0003, 16'h0005);
    set_wr(1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset rd", rd, 32'h0);
    chk("reset in_ready", in_ready, 1'b0);

    // Plain register-file read.
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk("t1 out_valid", out_valid, 1'b1);
    chk("t1 rd", rd, 32'h0005_0003);
    chk("t1 fwd_sel", fwd_sel, 4'b0000);

    // EX beats WB, then WB alone.
    set_req(1'b1, 4'd7, 4'd7, 2'b11, 16'h0707, 16'h0707);
    set_wr(1'b1, 4'd7, 1'b1, 16'hBEEF, 1'b1, 4'd7, 16'h1111);
    tick();
    chk("t2 ex rd", rd, 32'hBEEF_BEEF);
    chk("t2 ex fwd_sel", fwd_sel, 4'b1010);
    ex_wr_en = 1'b0;
    tick();
    chk("t2 wb rd", rd, 32'h1111_1111);
    chk("t2 wb fwd_sel", fwd_sel, 4'b0101);

    // Load-use stall for 3 cycles.
    in_valid = 1'b0;
    tick();
    set_req(1'b1, 4'd4, 4'd0, 2'b01, 16'h0404, 16'h0);
    set_wr(1'b1, 4'd4, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3 stall in_ready", in_ready, 1'b0);
      tick();
    end
    ex_wr_data_valid = 1'b1; ex_wr_data = 16'h00AA;
    @(negedge clk);
    chk("t3 resolve in_ready", in_ready, 1'b1);
    tick();
    chk("t3 rd", rd, 32'h0000_00AA);
    chk("t3 fwd_sel", fwd_sel, 4'b0010);
`ifdef REG_READ_FWD_STATS_EN
    chk("t3 stall_cnt", stall_cnt, 4'd3);
    chk("t3 fwd_ex_cnt", fwd_ex_cnt, 4'd2);
    chk("t3 fwd_wb_cnt", fwd_wb_cnt, 4'd1);
`endif

    // Same collision but port disabled: no stall.
    ex_wr_data_valid = 1'b0;
    rn_en = 2'b00;
    @(negedge clk);
    chk("t4 in_ready", in_ready, 1'b1);
    tick();
    chk("t4 rd", rd, 32'h0);
    chk("t4 out_valid", out_valid, 1'b1);

    // Out-of-range register number on port 0.
    set_req(1'b1, 4'd13, 4'd2, 2'b11, 16'hDEAD, 16'h2222);
    set_wr(1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
    tick();
    chk("t5 exception", exception, 2'b01);
    chk("t5 rd", rd, 32'h2222_0000);
    chk("t5 out_valid", out_valid, 1'b1);

    // Backpressure, then back-to-back, then reset mid-hold.
    set_req(1'b1, 4'd1, 4'd0, 2'b01, 16'h0101, 16'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6 hold in_ready", in_ready, 1'b0);
      chk("t6 hold rd", rd, 32'h2222_0000);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t6 b2b first rd", rd, 32'h0000_0101);
    set_req(1'b1, 4'd2, 4'd0, 2'b01, 16'h0202, 16'h0);
    tick();
    chk("t6 b2b second rd", rd, 32'h0000_0202);
    chk("t6 b2b out_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t6 rst out_valid", out_valid, 1'b0);
    chk("t6 rst rd", rd, 32'h0);
    chk("t6 rst in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hold = in_valid && !in_ready && rst;
      @(posedge clk); #1;
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rn       = 8'($urandom);
        rn_en    = 2'($urandom);
      end
      rfile_data       = 32'($urandom);
      ex_wr_en         = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) ex_wr_num = rn[4*$urandom_range(0, 1) +: 4];
      else ex_wr_num = 4'($urandom);
      ex_wr_data_valid = 1'($urandom_range(0, 1));
      ex_wr_data       = 16'($urandom);
      wb_wr_en         = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) wb_wr_num = rn[4*$urandom_range(0, 1) +: 4];
      else wb_wr_num = 4'($urandom);
      wb_wr_data       = 16'($urandom);
      out_ready        = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
